// File: rtl/soc_top.sv
// rtl/soc_top.sv - four-note tone generator with LED PWM and optional UART note report
//
// Plays one of four square-wave notes selected by active-low keys (priority
// DO > RE > MI > FA), drives a note-active LED and an LED brightness PWM
// whose duty depends on the note.
//
// Optional feature macro: UART_NOTE_TX_EN
//   defined   : every transition into a new note sends one 8N1 frame ('C'..'F')
//   undefined : TXD is tied high and no UART logic exists
//
// Ports:
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   BUTTONS_IN[3:0] note keys, active-low (bit0=DO, bit1=RE, bit2=MI, bit3=FA)
//   RXD            UART receive, unused
//   TXD            UART transmit, idle high
//   PWM_AUDIO_OUT  square-wave tone
//   PWM_LED_OUT    LED brightness PWM
//   LEDS           note-active indicator
module soc_top #(
    parameter int CLK_HZ = 25000000,
    parameter int DIV_DO = 23860,
    parameter int DIV_RE = 21302,
    parameter int DIV_MI = 18977,
    parameter int DIV_FA = 17906,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] BUTTONS_IN,
    input  logic       RXD,
    output logic       TXD,
    output logic       PWM_AUDIO_OUT,
    output logic       PWM_LED_OUT,
    output logic       LEDS
);

    localparam logic [15:0] BIT_CYC = 16'(CLK_HZ / BAUD);

    typedef enum logic [2:0] {N_SILENT, N_DO, N_RE, N_MI, N_FA} note_t;

    logic [3:0]  btn_s1, btn_s2;
    note_t       sel, note_q;
    logic [15:0] div_cnt, sel_div;
    logic [7:0]  pwm_cnt, duty;

    // RXD is intentionally ignored; BIT_CYC is only consumed by the UART build.
    logic unused_sig;
    assign unused_sig = RXD | (BIT_CYC == 16'd0);

    always_comb begin
        sel = N_SILENT;
        if      (btn_s2[0]) sel = N_DO;
        else if (btn_s2[1]) sel = N_RE;
        else if (btn_s2[2]) sel = N_MI;
        else if (btn_s2[3]) sel = N_FA;
    end

    always_comb begin
        sel_div = 16'd0;
        duty    = 8'd0;
        case (note_q)
            N_DO:    begin sel_div = 16'(DIV_DO); duty = 8'd255; end
            N_RE:    begin sel_div = 16'(DIV_RE); duty = 8'd192; end
            N_MI:    begin sel_div = 16'(DIV_MI); duty = 8'd128; end
            N_FA:    begin sel_div = 16'(DIV_FA); duty = 8'd64;  end
            default: begin sel_div = 16'd0;       duty = 8'd0;   end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_s1        <= 4'd0;
            btn_s2        <= 4'd0;
            note_q        <= N_SILENT;
            div_cnt       <= 16'd0;
            PWM_AUDIO_OUT <= 1'b0;
            LEDS          <= 1'b0;
            pwm_cnt       <= 8'd0;
            PWM_LED_OUT   <= 1'b0;
        end else begin
            btn_s1      <= ~BUTTONS_IN;
            btn_s2      <= btn_s1;
            note_q      <= sel;
            LEDS        <= (sel != N_SILENT);
            pwm_cnt     <= pwm_cnt + 8'd1;
            PWM_LED_OUT <= (pwm_cnt < duty);
            // A note change restarts the waveform from a full low phase.
            if (sel != note_q || note_q == N_SILENT) begin
                div_cnt       <= 16'd0;
                PWM_AUDIO_OUT <= 1'b0;
            end else if (sel_div <= 16'd1 || div_cnt == sel_div - 16'd1) begin
                div_cnt       <= 16'd0;
                PWM_AUDIO_OUT <= ~PWM_AUDIO_OUT;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

`ifdef UART_NOTE_TX_EN
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        pend_v_q, pend_v_d;
    logic [7:0]  pend_ch_q, pend_ch_d;
    logic        new_ch_v, bit_end, txd_d;
    logic [7:0]  new_ch;

    always_comb begin
        new_ch_v = (sel != note_q) && (sel != N_SILENT);
        case (sel)
            N_DO:    new_ch = 8'h43;
            N_RE:    new_ch = 8'h44;
            N_MI:    new_ch = 8'h45;
            default: new_ch = 8'h46;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        pend_v_d   = pend_v_q;
        pend_ch_d  = pend_ch_q;
        bit_end    = (BIT_CYC <= 16'd1) || (bit_cnt_q == BIT_CYC - 16'd1);
        case (tx_state_q)
            TX_IDLE: begin
                bit_cnt_d = 16'd0;
                bit_idx_d = 3'd0;
                // A fresh note beats a stale pending one (latest wins).
                if (new_ch_v) begin
                    shreg_d    = new_ch;
                    pend_v_d   = 1'b0;
                    tx_state_d = TX_START;
                end else if (pend_v_q) begin
                    shreg_d    = pend_ch_q;
                    pend_v_d   = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            default: begin
                if (new_ch_v) begin
                    pend_v_d  = 1'b1;
                    pend_ch_d = new_ch;
                end
                if (bit_end) begin
                    bit_cnt_d = 16'd0;
                    case (tx_state_q)
                        TX_START: tx_state_d = TX_DATA;
                        TX_DATA: begin
                            if (bit_idx_q == 3'd7) tx_state_d = TX_STOP;
                            else                   bit_idx_d  = bit_idx_q + 3'd1;
                        end
                        default:  tx_state_d = TX_IDLE;
                    endcase
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
        endcase
        // TXD is registered from the next-state view so line and state stay aligned.
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shreg_d[bit_idx_d];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state_q <= TX_IDLE;
            bit_cnt_q  <= 16'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'd0;
            pend_v_q   <= 1'b0;
            pend_ch_q  <= 8'd0;
            TXD        <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            pend_v_q   <= pend_v_d;
            pend_ch_q  <= pend_ch_d;
            TXD        <= txd_d;
        end
    end
`else
    assign TXD = 1'b1;
`endif

endmodule

// File: tb/tb_soc_top.sv
// tb/tb_soc_top.sv - directed self-checking bench for soc_top
module tb_soc_top;

    localparam int D_DO = 10;
    localparam int D_RE = 7;
    localparam int D_MI = 4;
    localparam int D_FA = 1;
    localparam int BITC = 25000000 / 115200;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] BUTTONS_IN;
    logic       RXD;
    logic       TXD;
    logic       PWM_AUDIO_OUT;
    logic       PWM_LED_OUT;
    logic       LEDS;

    int n_chk  = 0;
    int n_fail = 0;
    logic txd_low_seen = 1'b0;

    soc_top #(
        .CLK_HZ(25000000), .DIV_DO(D_DO), .DIV_RE(D_RE),
        .DIV_MI(D_MI), .DIV_FA(D_FA), .BAUD(115200)
    ) dut (
        .clk(clk), .resetn(resetn), .BUTTONS_IN(BUTTONS_IN), .RXD(RXD),
        .TXD(TXD), .PWM_AUDIO_OUT(PWM_AUDIO_OUT), .PWM_LED_OUT(PWM_LED_OUT),
        .LEDS(LEDS)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (TXD !== 1'b1) txd_low_seen <= 1'b1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for a rising edge of the tone, then counts one high and one low phase.
    task automatic measure(output int hi, output int lo);
        int b;
        hi = 0; lo = 0;
        b = 0;
        while (PWM_AUDIO_OUT !== 1'b0 && b < 1000) begin b++; cyc(1); end
        b = 0;
        while (PWM_AUDIO_OUT !== 1'b1 && b < 1000) begin b++; cyc(1); end
        if (b >= 1000) return;
        while (PWM_AUDIO_OUT === 1'b1 && hi < 1000) begin hi++; cyc(1); end
        while (PWM_AUDIO_OUT === 1'b0 && lo < 1000) begin lo++; cyc(1); end
    endtask

    task automatic note_check(input string tag, input logic [3:0] keys, input int div);
        int hi, lo;
        BUTTONS_IN = keys;
        cyc(5);
        measure(hi, lo);
        chk({tag, "_high"}, hi, div);
        chk({tag, "_low"}, lo, div);
        chk({tag, "_leds"}, int'(LEDS), 1);
    endtask

    task automatic led_duty(input string tag, input int exp);
        int h = 0;
        for (int i = 0; i < 256; i++) begin
            if (PWM_LED_OUT === 1'b1) h++;
            cyc(1);
        end
        chk(tag, h, exp);
    endtask

    task automatic quiet(input string tag);
        int h = 0;
        for (int i = 0; i < 400; i++) begin
            RXD = 1'($urandom_range(0, 1));
            if (PWM_AUDIO_OUT !== 1'b0) h++;
            cyc(1);
        end
        chk(tag, h, 0);
    endtask

    initial begin
        int b;
        resetn     = 1'b0;
        BUTTONS_IN = 4'hF;
        RXD        = 1'b1;
        cyc(5);
        chk("rst_audio", int'(PWM_AUDIO_OUT), 0);
        chk("rst_ledpwm", int'(PWM_LED_OUT), 0);
        chk("rst_leds", int'(LEDS), 0);
        chk("rst_txd", int'(TXD), 1);
        resetn = 1'b1;
        cyc(20);

        quiet("idle_audio");
        chk("idle_leds", int'(LEDS), 0);
        led_duty("idle_ledpwm", 0);

        // Latency: LEDS rises on the 3rd edge, tone goes high DIV edges later.
        BUTTONS_IN = 4'b1110;
        cyc(2);
        chk("lat_leds_2", int'(LEDS), 0);
        cyc(1);
        chk("lat_leds_3", int'(LEDS), 1);
        cyc(D_DO - 1);
        chk("lat_low_end", int'(PWM_AUDIO_OUT), 0);
        cyc(1);
        chk("lat_first_high", int'(PWM_AUDIO_OUT), 1);

        note_check("do", 4'b1110, D_DO);
        led_duty("do_ledpwm", 255);
        note_check("re", 4'b1101, D_RE);
        led_duty("re_ledpwm", 192);
        note_check("mi", 4'b1011, D_MI);
        led_duty("mi_ledpwm", 128);
        note_check("fa", 4'b0111, D_FA);
        led_duty("fa_ledpwm", 64);
        note_check("all_keys", 4'b0000, D_DO);
        led_duty("all_ledpwm", 255);
        note_check("re_mi", 4'b1001, D_RE);

        BUTTONS_IN = 4'hF;
        cyc(3);
        chk("rel_audio", int'(PWM_AUDIO_OUT), 0);
        chk("rel_leds", int'(LEDS), 0);
        quiet("rel_quiet");

        // Asynchronous reset while DO is high, checked before the next rising edge.
        BUTTONS_IN = 4'b1110;
        b = 0;
        cyc(4);
        while (PWM_AUDIO_OUT !== 1'b1 && b < 200) begin b++; cyc(1); end
        chk("arst_pre_high", int'(PWM_AUDIO_OUT), 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_audio", int'(PWM_AUDIO_OUT), 0);
        chk("arst_txd", int'(TXD), 1);
        chk("arst_leds", int'(LEDS), 0);
        BUTTONS_IN = 4'hF;
        cyc(3);
        resetn = 1'b1;
        cyc(5);
        chk("arst_after_leds", int'(LEDS), 0);
        quiet("arst_after_quiet");

`ifdef UART_NOTE_TX_EN
        begin
            logic [7:0] rx;
            BUTTONS_IN = 4'b1101;
            b = 0;
            while (TXD !== 1'b0 && b < 100) begin b++; cyc(1); end
            cyc(BITC / 2);
            chk("uart_start", int'(TXD), 0);
            for (int i = 0; i < 8; i++) begin
                cyc(BITC);
                rx[i] = TXD;
            end
            chk("uart_data", int'(rx), 8'h44);
            cyc(BITC);
            chk("uart_stop", int'(TXD), 1);
        end
`else
        chk("txd_never_low", int'(txd_low_seen), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_top.md
SOC_TOP -- requirements
Module: soc_top

Interface
REQ-001 Parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 Parameters DIV_DO/DIV_RE/DIV_MI/DIV_FA, defaults 23860/21302/18977/17906, half-period lengths of each note in clock cycles.
REQ-003 Parameter BAUD, default 115200, UART bit rate.
REQ-004 clk  input  1  single system clock, rising-edge active.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 BUTTONS_IN  input  4  note keys, active-low: bit0=DO, bit1=RE, bit2=MI, bit3=FA.
REQ-007 RXD  input  1  UART receive; SHALL be ignored, no effect on any output.
REQ-008 TXD  output  1  UART transmit, idle high.
REQ-009 PWM_AUDIO_OUT  output  1  square-wave tone output.
REQ-010 PWM_LED_OUT  output  1  LED brightness PWM.
REQ-011 LEDS  output  1  note-active indicator.

Function
REQ-012 BUTTONS_IN SHALL be inverted and passed through a 2-flop synchronizer; the resulting pressed vector has a fixed latency of 2 clk cycles.
REQ-013 Note select priority SHALL be DO > RE > MI > FA; if no bit is pressed, state is SILENT.
REQ-014 SILENT: PWM_AUDIO_OUT SHALL be 0 every cycle and the divider counter held at 0.
REQ-015 Active note: a counter counts 0..DIV-1; on reaching DIV-1 it wraps to 0 and PWM_AUDIO_OUT toggles, giving exactly DIV cycles high and DIV cycles low.
REQ-016 Any change of selected note (including SILENT to note) SHALL clear the counter and drive PWM_AUDIO_OUT to 0 in the same cycle; the first high phase starts DIV cycles later.
REQ-017 Counter width SHALL be 16 bits minimum; a DIV value of 0 or 1 SHALL toggle the output every cycle.
REQ-018 LEDS[0] SHALL be 1 whenever the selected note is not SILENT, else 0, registered.
REQ-019 An 8-bit free-running counter SHALL drive PWM_LED_OUT = (counter < duty); duty is SILENT 0, FA 64, MI 128, RE 192, DO 255.
REQ-020 All outputs SHALL be registered; no combinational path from BUTTONS_IN to any output.

Reset
REQ-021 While resetn=0: PWM_AUDIO_OUT=0, PWM_LED_OUT=0, LEDS=0, TXD=1, all counters and synchronizers 0 (no key pressed), UART idle.
REQ-022 Reset asserted mid-tone or mid-UART-frame SHALL abort immediately; after release, operation restarts from SILENT.

Configuration
REQ-023 Macro UART_NOTE_TX_EN: when defined, each transition into a new non-SILENT note SHALL transmit one 8N1 frame at BAUD (bit time CLK_HZ/BAUD cycles, integer division) carrying ASCII 'C','D','E','F' for DO/RE/MI/FA.
REQ-024 With UART_NOTE_TX_EN defined, a note change while a frame is in flight SHALL be held in a one-deep pending register (latest wins) and sent after the current stop bit.
REQ-025 Without UART_NOTE_TX_EN, TXD SHALL be constant 1 and no UART logic is synthesized.

Verification
REQ-026 Reset 1 ms, release, all keys up for 2 ms -> PWM_AUDIO_OUT=0 for 400 consecutive cycles, LEDS=0, PWM_LED_OUT=0.
REQ-027 Press each key alone (BUTTONS_IN=1110,1101,1011,0111), wait 2 ms -> one full period measures high=low=23860, 21302, 18977, 17906 respectively; LEDS=1.
REQ-028 BUTTONS_IN=0000 -> high=low=23860 (DO priority); PWM_LED_OUT high 255 of every 256 cycles.
REQ-029 Release all after any note -> PWM_AUDIO_OUT=0 within 3 cycles and for 400 following cycles; LEDS=0 after 3 cycles.
REQ-030 With UART_NOTE_TX_EN, press RE -> TXD frame decodes 0x44 at 217-cycle bit time; without macro, TXD stays 1 throughout.
REQ-031 Assert resetn low mid-DO-tone -> PWM_AUDIO_OUT=0 and TXD=1 asynchronously, before the next clk edge.
